// File: rtl/mul_pkg.sv
// Shared definitions for the serial shift-add multiply-accumulate unit.
//   state_e   : FSM state encoding (IDLE=0, RUN=1, FIX=2, DONE=3)
//   DefDataW  : default operand width
package mul_pkg;

  parameter int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/mul_fix.sv
// Final correction stage of the multiply-accumulate: conditionally negates the
// magnitude product and adds the extended addend, modulo 2^ProdW.
//   i_neg        : result sign (1 = negate accumulator)
//   i_acc        : unsigned magnitude product
//   i_addend_ext : sign- or zero-extended addend
//   o_sum        : (i_neg ? -i_acc : i_acc) + i_addend_ext
module mul_fix #(
  parameter int unsigned ProdW = 64
) (
  input  logic             i_neg,
  input  logic [ProdW-1:0] i_acc,
  input  logic [ProdW-1:0] i_addend_ext,
  output logic [ProdW-1:0] o_sum
);

  logic [ProdW-1:0] w_signed_acc;

  always_comb begin
    w_signed_acc = i_neg ? (~i_acc + ProdW'(1)) : i_acc;
    o_sum        = w_signed_acc + i_addend_ext;
  end

endmodule

// File: rtl/mul_shiftadd.sv
// Serial shift-add multiply-accumulate: product = op_a * op_b + addend,
// one multiplier bit per cycle over DATA_W cycles, signed or unsigned.
//   i_clk     : clock, rising edge
//   i_rst_n   : synchronous active-low reset
//   i_en      : level-sensitive start/hold request
//   i_sign    : 1 = two's-complement operands and addend, 0 = unsigned
//   i_op_a    : multiplicand
//   i_op_b    : multiplier
//   i_addend  : accumulated term
//   o_done    : result valid (registered)
//   o_product : 2*DATA_W result (registered)
module mul_shiftadd
  import mul_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_sign,
  input  logic [DATA_W-1:0]   i_op_a,
  input  logic [DATA_W-1:0]   i_op_b,
  input  logic [DATA_W-1:0]   i_addend,
  output logic                o_done,
  output logic [2*DATA_W-1:0] o_product
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned CntW  = $clog2(DATA_W) + 1;

  state_e              r_state;
  logic                r_sign;
  logic                r_neg;
  logic [DATA_W-1:0]   r_addend;
  logic [ProdW-1:0]    r_mcand;   // multiplicand, pre-shifted by the iteration index
  logic [DATA_W-1:0]   r_mplier;
  logic [ProdW-1:0]    r_acc;
  logic [CntW-1:0]     r_cnt;
  logic                r_done;
  logic [ProdW-1:0]    r_product;

  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic                w_neg;
  logic [ProdW-1:0]    w_addend_ext;
  logic [ProdW-1:0]    w_fix_sum;
  logic                w_last;

  // Magnitudes as unsigned values; the most negative number maps onto 2^(DATA_W-1).
  always_comb begin
    w_mag_a      = (i_sign && i_op_a[DATA_W-1]) ? (~i_op_a + DATA_W'(1)) : i_op_a;
    w_mag_b      = (i_sign && i_op_b[DATA_W-1]) ? (~i_op_b + DATA_W'(1)) : i_op_b;
    w_neg        = i_sign & (i_op_a[DATA_W-1] ^ i_op_b[DATA_W-1]);
    w_addend_ext = r_sign ? {{DATA_W{r_addend[DATA_W-1]}}, r_addend}
                          : {{DATA_W{1'b0}}, r_addend};
    w_last       = (r_cnt == CntW'(DATA_W - 1));
  end

  mul_fix #(
    .ProdW (ProdW)
  ) u_fix (
    .i_neg        (r_neg),
    .i_acc        (r_acc),
    .i_addend_ext (w_addend_ext),
    .o_sum        (w_fix_sum)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_sign    <= 1'b0;
      r_neg     <= 1'b0;
      r_addend  <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (i_en) begin
            r_sign   <= i_sign;
            r_neg    <= w_neg;
            r_addend <= i_addend;
            r_mcand  <= {{DATA_W{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= StRun;
          end
        end
        StRun: begin
          if (!i_en) begin
            r_state <= StIdle;
          end else begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CntW'(1);
            if (w_last) begin
              r_state <= StFix;
            end
          end
        end
        StFix: begin
          if (!i_en) begin
            r_state <= StIdle;
          end else begin
            r_product <= w_fix_sum;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end
        end
        StDone: begin
          if (!i_en) begin
            r_done  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_mul_shiftadd.sv
module tb_mul_shiftadd;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] addend;
  logic        done;
  logic [63:0] product;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] exp_q[$];
  logic        prev_done = 1'b0;

  mul_shiftadd #(
    .DATA_W (32)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_sign    (sign),
    .i_op_a    (op_a),
    .i_op_b    (op_b),
    .i_addend  (addend),
    .o_done    (done),
    .o_product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the arithmetic meaning of a*b+c in 64 bits.
  function automatic logic [63:0] ref_mac(input bit s, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
    longint      sa, sb, sc;
    logic [63:0] ua, ub, uc;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sc = longint'($signed(c));
      return 64'(sa * sb + sc);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uc = {32'd0, c};
    return ua * ub + uc;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Monitor: every rising done must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1 && prev_done !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          check("product", product, exp_q.pop_front());
        end
      end
      prev_done = done;
    end
  end

  // Drive operands, raise en and return after the capture edge E0.
  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input bit push, input logic [63:0] exp);
    @(negedge clk);
    sign   = s;
    op_a   = a;
    op_b   = b;
    addend = c;
    en     = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    // Inputs only need to be stable at capture.
    #1;
    op_a   = $urandom;
    op_b   = $urandom;
    addend = $urandom;
    sign   = ~s;
  endtask

  // Wait for done (bounded), optionally check latency, then release en.
  task automatic finish_op(input bit chk_lat);
    int edges;
    edges = 1;
    while (edges < 100 && done !== 1'b1) begin
      @(posedge clk);
      edges++;
      #1;
    end
    if (done !== 1'b1) begin
      check("done_timeout", {63'd0, done}, 64'd1);
    end else if (chk_lat) begin
      check("latency_edges", 64'(edges), 64'd34);
    end
    repeat (2) @(posedge clk);
    #1;
    check("done_hold", {63'd0, done}, 64'd1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("done_fall", {63'd0, done}, 64'd0);
  endtask

  task automatic full_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [63:0] exp, input bit chk_lat);
    start_op(s, a, b, c, 1'b1, exp);
    finish_op(chk_lat);
  endtask

  initial begin
    logic [31:0] dvd, dvs, quo, rem, ra, rb, rc;
    bit          rs;

    rst_n  = 1'b0;
    en     = 1'b0;
    sign   = 1'b0;
    op_a   = '0;
    op_b   = '0;
    addend = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived results.
    full_op(1'b0, 32'd7, 32'd6, 32'd5, 64'd47, 1'b1);
    full_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b1);
    full_op(1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFE9, 1'b1);
    full_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 64'h4000_0000_7FFF_FFFF, 1'b1);
    full_op(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_0000_0000, 1'b0);
    full_op(1'b0, 32'd0, 32'hDEAD_BEEF, 32'd0, 64'd0, 1'b0);

    // Abort mid-RUN after a result of 47.
    full_op(1'b0, 32'd7, 32'd6, 32'd5, 64'd47, 1'b0);
    start_op(1'b0, 32'd123, 32'd456, 32'd1, 1'b0, 64'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", product, 64'd47);
    full_op(1'b0, 32'd123, 32'd456, 32'd789, 64'd56877, 1'b0);

    // Reset mid-RUN.
    start_op(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd3, 1'b0, 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    check("midrun_reset_product", product, 64'd0);
    check("midrun_reset_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    full_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0);

    // Random signed/unsigned MAC against the arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      rc = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      full_op(rs, ra, rb, rc, ref_mac(rs, ra, rb, rc), 1'b0);
    end

    // Divider round-trip: quotient*divisor+remainder rebuilds the dividend.
    for (int i = 0; i < 1000; i++) begin
      dvd = $urandom;
      dvs = $urandom;
      if ($urandom_range(0, 2) == 0) dvs = $urandom_range(1, 255);
      if (dvs == 0) dvs = 32'd1;
      quo = dvd / dvs;
      rem = dvd % dvs;
      full_op(1'b0, quo, dvs, rem, {32'd0, dvd}, 1'b0);
    end

    repeat (5) @(posedge clk);
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
